// File: rtl/smvm_ctrl.sv
// Sparse matrix-vector multiply input controller.
// Loads the dense vector into vector RAM, then packs (value, column, row-end)
// nonzeros into K-slot batches for the datapath, counts issued rows and
// returned row results, and pulses done once every row result is back.
module smvm_ctrl #(
    parameter int K = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       data_in,
    input  logic             ipv_in,
    input  logic             in_last,
    output logic             vec_we,
    output logic [6:0]       vec_addr,
    output logic [7:0]       vec_wdata,
    output logic             batch_valid,
    output logic [8*K-1:0]   batch_val,
    output logic [7*K-1:0]   batch_col,
    output logic [K-1:0]     batch_ipv,
    input  logic             res_valid,
    output logic             busy,
    output logic             done,
    output logic [7:0]       row_count
);

    localparam int SW = (K > 1) ? $clog2(K) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(K - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_VEC  = 3'd1,
        S_VAL  = 3'd2,
        S_COL  = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cols_q, cols_d;
    logic [6:0]       vec_idx_q, vec_idx_d;
    logic [SW-1:0]    slot_q, slot_d;
    logic [7:0]       val_q [K];
    logic [7:0]       val_d [K];
    logic [6:0]       col_q [K];
    logic [6:0]       col_d [K];
    logic             ipv_q [K];
    logic             ipv_d [K];
    logic [7:0]       row_cnt_q, row_cnt_d;
    logic [7:0]       res_cnt_q, res_cnt_d;
    logic [8*K-1:0]   bval_q, bval_d;
    logic [7*K-1:0]   bcol_q, bcol_d;
    logic [K-1:0]     bipv_q, bipv_d;
    logic             bvalid_q, bvalid_d;
    logic             done_q, done_d;

    logic             in_ready_s;
    logic             beat_s;
    logic [7:0]       res_cnt_inc_s;

    // Handshake: the controller only refuses beats while draining results.
    always_comb begin
        in_ready_s    = (state_q != S_WAIT);
        beat_s        = in_valid && in_ready_s;
        res_cnt_inc_s = res_cnt_q + {7'd0, res_valid};
    end

    // Next-state and datapath-register update logic for the job FSM.
    always_comb begin
        state_d   = state_q;
        cols_d    = cols_q;
        vec_idx_d = vec_idx_q;
        slot_d    = slot_q;
        val_d     = val_q;
        col_d     = col_q;
        ipv_d     = ipv_q;
        row_cnt_d = row_cnt_q;
        bval_d    = bval_q;
        bcol_d    = bcol_q;
        bipv_d    = bipv_q;
        bvalid_d  = 1'b0;
        done_d    = 1'b0;

        // Row results count everywhere except IDLE; a new job clears below.
        if (state_q != S_IDLE) begin
            res_cnt_d = res_cnt_inc_s;
        end else begin
            res_cnt_d = res_cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (beat_s) begin
                    cols_d    = {1'b0, data_in[6:0]} + 8'd1;
                    vec_idx_d = 7'd0;
                    slot_d    = {SW{1'b0}};
                    row_cnt_d = 8'd0;
                    res_cnt_d = 8'd0;
                    state_d   = S_VEC;
                end else begin
                    state_d   = S_IDLE;
                end
            end

            S_VEC: begin
                if (beat_s) begin
                    vec_idx_d = vec_idx_q + 7'd1;
                    if ({1'b0, vec_idx_q} == (cols_q - 8'd1)) begin
                        state_d = S_VAL;
                    end else begin
                        state_d = S_VEC;
                    end
                end else begin
                    state_d = S_VEC;
                end
            end

            S_VAL: begin
                if (beat_s) begin
                    val_d[slot_q] = data_in;
                    state_d       = S_COL;
                end else begin
                    state_d       = S_VAL;
                end
            end

            S_COL: begin
                if (beat_s) begin
                    col_d[slot_q] = data_in[6:0];
                    ipv_d[slot_q] = ipv_in;
                    if (ipv_in) begin
                        row_cnt_d = row_cnt_q + 8'd1;
                    end else begin
                        row_cnt_d = row_cnt_q;
                    end

                    // Close the batch: the current beat fills slot_q directly,
                    // earlier slots come from the registers, later ones are zero.
                    if ((slot_q == SLOT_LAST) || in_last) begin
                        for (int i = 0; i < K; i++) begin
                            if (SW'(i) < slot_q) begin
                                bval_d[8*K-1-8*i -: 8] = val_q[i];
                                bcol_d[7*K-1-7*i -: 7] = col_q[i];
                                bipv_d[K-1-i]          = ipv_q[i];
                            end else if (SW'(i) == slot_q) begin
                                bval_d[8*K-1-8*i -: 8] = val_q[i];
                                bcol_d[7*K-1-7*i -: 7] = data_in[6:0];
                                bipv_d[K-1-i]          = ipv_in;
                            end else begin
                                bval_d[8*K-1-8*i -: 8] = 8'd0;
                                bcol_d[7*K-1-7*i -: 7] = 7'd0;
                                bipv_d[K-1-i]          = 1'b0;
                            end
                        end
                        bvalid_d = 1'b1;
                        slot_d   = {SW{1'b0}};
                    end else begin
                        slot_d   = slot_q + {{(SW-1){1'b0}}, 1'b1};
                    end

                    if (in_last) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_VAL;
                    end
                end else begin
                    state_d = S_COL;
                end
            end

            S_WAIT: begin
                // Includes a result arriving in this very cycle.
                if (res_cnt_inc_s == row_cnt_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and register bank with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cols_q    <= 8'd0;
            vec_idx_q <= 7'd0;
            slot_q    <= {SW{1'b0}};
            for (int i = 0; i < K; i++) begin
                val_q[i] <= 8'd0;
                col_q[i] <= 7'd0;
                ipv_q[i] <= 1'b0;
            end
            row_cnt_q <= 8'd0;
            res_cnt_q <= 8'd0;
            bval_q    <= '0;
            bcol_q    <= '0;
            bipv_q    <= '0;
            bvalid_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cols_q    <= cols_d;
            vec_idx_q <= vec_idx_d;
            slot_q    <= slot_d;
            for (int i = 0; i < K; i++) begin
                val_q[i] <= val_d[i];
                col_q[i] <= col_d[i];
                ipv_q[i] <= ipv_d[i];
            end
            row_cnt_q <= row_cnt_d;
            res_cnt_q <= res_cnt_d;
            bval_q    <= bval_d;
            bcol_q    <= bcol_d;
            bipv_q    <= bipv_d;
            bvalid_q  <= bvalid_d;
            done_q    <= done_d;
        end
    end

    // Output mapping; the vector RAM write is combinational with the beat.
    always_comb begin
        in_ready    = in_ready_s;
        vec_we      = (state_q == S_VEC) && in_valid;
        vec_addr    = vec_idx_q;
        vec_wdata   = data_in;
        batch_valid = bvalid_q;
        batch_val   = bval_q;
        batch_col   = bcol_q;
        batch_ipv   = bipv_q;
        busy        = (state_q != S_IDLE);
        done        = done_q;
        row_count   = row_cnt_q;
    end

endmodule

// File: tb/tb_smvm_ctrl.sv
// Scoreboard bench for smvm_ctrl: stimulus pushes expected vector writes,
// batches and done events; a negedge monitor pops and compares.
module tb_smvm_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [7:0]  data_in;
    logic        ipv_in, in_last;
    logic        vec_we;
    logic [6:0]  vec_addr;
    logic [7:0]  vec_wdata;
    logic        batch_valid;
    logic [31:0] batch_val;
    logic [27:0] batch_col;
    logic [3:0]  batch_ipv;
    logic        res_valid;
    logic        busy, done;
    logic [7:0]  row_count;

    always #5 clk = ~clk;

    smvm_ctrl #(.K(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .ipv_in(ipv_in), .in_last(in_last),
        .vec_we(vec_we), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
        .batch_valid(batch_valid), .batch_val(batch_val), .batch_col(batch_col),
        .batch_ipv(batch_ipv), .res_valid(res_valid), .busy(busy), .done(done),
        .row_count(row_count)
    );

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [31:0] v;
        logic [27:0] c;
        logic [3:0]  p;
    } batch_t;

    logic [14:0] vec_q [$];
    batch_t      bat_q [$];
    logic [7:0]  done_q [$];
    int          done_cnt = 0;

    // current job description (reference model input)
    logic [7:0]  job_vec [$];
    logic [7:0]  job_val [$];
    logic [6:0]  job_col [$];
    bit          job_ipv [$];
    bit          force_res_last = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic unexpected(input string nm);
        checks++;
        $display("FAIL %s: got an unexpected event expected none at %0t", nm, $time);
    endtask

    // expected batch = nonzeros start..start+3 of the job, zero-filled
    function automatic batch_t make_batch(input int start);
        batch_t b;
        b.v = 32'd0; b.c = 28'd0; b.p = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (start + i < job_val.size()) begin
                b.v[31-8*i -: 8] = job_val[start+i];
                b.c[27-7*i -: 7] = job_col[start+i];
                b.p[3-i]         = job_ipv[start+i];
            end
        end
        return b;
    endfunction

    // monitor
    initial begin
        logic prev_bv;
        prev_bv = 1'b0;
        forever begin
            @(negedge clk);
            if (vec_we) begin
                if (vec_q.size() == 0) unexpected("vec_we");
                else begin
                    logic [14:0] e;
                    e = vec_q.pop_front();
                    chk("vec_addr", {25'd0, vec_addr}, {25'd0, e[14:8]});
                    chk("vec_wdata", {24'd0, vec_wdata}, {24'd0, e[7:0]});
                end
            end
            if (batch_valid) begin
                chk("batch_not_consecutive", {31'd0, prev_bv}, 32'd0);
                if (bat_q.size() == 0) unexpected("batch_valid");
                else begin
                    batch_t b;
                    b = bat_q.pop_front();
                    chk("batch_val", batch_val, b.v);
                    chk("batch_col", {4'd0, batch_col}, {4'd0, b.c});
                    chk("batch_ipv", {28'd0, batch_ipv}, {28'd0, b.p});
                end
            end
            prev_bv = batch_valid;
            if (done) begin
                if (done_q.size() == 0) unexpected("done");
                else begin
                    logic [7:0] r;
                    r = done_q.pop_front();
                    chk("done_row_count", {24'd0, row_count}, {24'd0, r});
                    chk("done_busy", {31'd0, busy}, 32'd0);
                    chk("done_in_ready", {31'd0, in_ready}, 32'd1);
                end
                done_cnt++;
            end
        end
    end

    task automatic drive(input bit v, input logic [7:0] d, input bit ip, input bit la, input bit rs);
        in_valid = v; data_in = d; ipv_in = ip; in_last = la; res_valid = rs;
        @(posedge clk); #1;
        in_valid = 1'b0; ipv_in = 1'b0; in_last = 1'b0; res_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_vec_we"}, {31'd0, vec_we}, 32'd0);
        chk({tag, "_batch_valid"}, {31'd0, batch_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_row_count"}, {24'd0, row_count}, 32'd0);
        chk({tag, "_batch_val"}, batch_val, 32'd0);
        chk({tag, "_batch_col"}, {4'd0, batch_col}, 32'd0);
        chk({tag, "_batch_ipv"}, {28'd0, batch_ipv}, 32'd0);
    endtask

    // Run one job from the job_* tables; abort_at >= 0 resets before that pair.
    task automatic run_job(input logic [7:0] shape, input int abort_at);
        int cols, n, rows_issued, res_sent, start_done;
        bit rs;
        cols = int'(shape[6:0]) + 1;
        n = job_val.size();
        rows_issued = 0;
        res_sent = 0;
        drive(1'b1, shape, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < cols; k++) begin
            if ($urandom_range(0, 5) == 0) drive(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
            vec_q.push_back({7'(k), job_vec[k]});
            drive(1'b1, job_vec[k], 1'b0, 1'b0, 1'b0);
        end
        for (int e = 0; e < n; e++) begin
            if (e == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midjob_reset");
                @(posedge clk); #1;
                rst_n = 1'b1;
                repeat (3) drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
                return;
            end
            if ($urandom_range(0, 4) == 0) begin
                rs = (res_sent < rows_issued) && ($urandom_range(0, 1) == 0);
                if (rs) res_sent++;
                drive(1'b0, 8'($urandom), 1'b0, 1'b0, rs);
            end
            rs = (res_sent < rows_issued) && ($urandom_range(0, 2) == 0);
            if (rs) res_sent++;
            drive(1'b1, job_val[e], 1'b0, 1'b0, rs);
            if ((e % 4 == 3) || (e == n - 1)) bat_q.push_back(make_batch(e - (e % 4)));
            rs = (res_sent < rows_issued) && ((force_res_last && e == n - 1) || ($urandom_range(0, 2) == 0));
            if (rs) res_sent++;
            drive(1'b1, {1'b0, job_col[e]}, job_ipv[e], e == n - 1, rs);
            if (job_ipv[e]) rows_issued++;
        end
        done_q.push_back(8'(rows_issued));
        start_done = done_cnt;
        // drain results; in WAIT the controller must refuse any beat
        while (res_sent < rows_issued) begin
            chk("wait_in_ready", {31'd0, in_ready}, 32'd0);
            chk("wait_busy", {31'd0, busy}, 32'd1);
            rs = ($urandom_range(0, 1) == 0);
            if (rs) res_sent++;
            drive($urandom_range(0, 1) == 1, 8'($urandom), 1'($urandom), 1'($urandom), rs);
        end
        for (int t = 0; t < 20 && done_cnt == start_done; t++) begin
            @(posedge clk); #1;
        end
        if (done_cnt == start_done) chk("done_timeout", 32'd0, 32'd1);
        repeat (3) drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_job();
        job_vec.delete(); job_val.delete(); job_col.delete(); job_ipv.delete();
    endtask

    task automatic add_nz(input logic [7:0] v, input logic [6:0] c, input bit p);
        job_val.push_back(v); job_col.push_back(c); job_ipv.push_back(p);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] shape;
        int n;
        rst_n = 1'b0; in_valid = 1'b0; data_in = 8'd0; ipv_in = 1'b0;
        in_last = 1'b0; res_valid = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);  // res_valid in IDLE is ignored

        // directed: shape 3, vector 1..4, four pairs, result on final beat
        clear_job();
        for (int k = 1; k <= 4; k++) job_vec.push_back(8'(k));
        add_nz(8'd5, 7'd0, 1'b0);
        add_nz(8'd6, 7'd1, 1'b0);
        add_nz(8'd7, 7'd2, 1'b1);
        add_nz(8'd8, 7'd3, 1'b1);
        force_res_last = 1'b1;
        run_job(8'h03, -1);
        force_res_last = 1'b0;
        chk("hold_batch_val", batch_val, 32'h05060708);
        chk("hold_batch_ipv", {28'd0, batch_ipv}, 32'd3);
        chk("hold_batch_col", {4'd0, batch_col}, {4'd0, 7'd0, 7'd1, 7'd2, 7'd3});

        // directed: six pairs -> full batch then half batch
        clear_job();
        job_vec.push_back(8'h9a);
        add_nz(8'h11, 7'd10, 1'b0);
        add_nz(8'h22, 7'd20, 1'b1);
        add_nz(8'h33, 7'd30, 1'b0);
        add_nz(8'h44, 7'd40, 1'b1);
        add_nz(8'h55, 7'd50, 1'b0);
        add_nz(8'h66, 7'd60, 1'b1);
        run_job(8'h80, -1);
        chk("half_batch_val", batch_val, 32'h55660000);
        chk("half_batch_ipv", {28'd0, batch_ipv}, 32'd4);

        // directed: reset during VAL after two pairs, then a fresh job
        clear_job();
        for (int k = 0; k < 2; k++) job_vec.push_back(8'($urandom));
        add_nz(8'h01, 7'd1, 1'b0);
        add_nz(8'h02, 7'd2, 1'b1);
        add_nz(8'h03, 7'd3, 1'b1);
        run_job(8'h01, 2);

        // randomized jobs
        for (int j = 0; j < 10; j++) begin
            clear_job();
            shape = 8'($urandom);
            if (j % 2 == 0) shape[6:4] = 3'd0;
            for (int k = 0; k <= int'(shape[6:0]); k++) job_vec.push_back(8'($urandom));
            n = $urandom_range(1, 13);
            for (int e = 0; e < n; e++)
                add_nz(8'($urandom), 7'($urandom), (e == n - 1) || ($urandom_range(0, 1) == 1));
            run_job(shape, -1);
        end

        chk("vec_q_empty", vec_q.size(), 32'd0);
        chk("bat_q_empty", bat_q.size(), 32'd0);
        chk("done_q_empty", done_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/smvm_ctrl.md
SMVM_CTRL -- requirements
Module: smvm_ctrl

Interface
REQ-001 Parameter K, default 4: nonzero entries per datapath batch; only K=4 is required.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  input beat valid.
REQ-005 in_ready  output  1  controller can accept a beat; a beat transfers when in_valid && in_ready.
REQ-006 data_in  input  8  shape / vector element / matrix value / column index, depending on state.
REQ-007 ipv_in  input  1  on a column beat: this nonzero is the last one of its row.
REQ-008 in_last  input  1  on a column beat: this nonzero is the last one of the matrix.
REQ-009 vec_we  output  1  vector RAM write strobe.
REQ-010 vec_addr  output  7  vector RAM write address.
REQ-011 vec_wdata  output  8  vector RAM write data.
REQ-012 batch_valid  output  1  one-cycle pulse; the batch buses hold a new batch.
REQ-013 batch_val  output  32  K signed 8-bit values; slot 0 is in bits [31:24].
REQ-014 batch_col  output  28  K 7-bit column indices; slot 0 is in bits [27:21].
REQ-015 batch_ipv  output  4  K row-end flags; slot 0 is in bit 3.
REQ-016 res_valid  input  1  datapath reports one completed row result.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse when all row results have returned.
REQ-019 row_count  output  8  number of rows issued in the current job.

Function
REQ-020 States SHALL be IDLE, VEC, VAL, COL, WAIT; in_ready SHALL be 1 in IDLE, VEC, VAL and COL, and 0 in WAIT.
REQ-021 IDLE, beat: cols := data_in[6:0]+1 (range 1..128); clear vec_idx, slot, row_count and res_cnt; go to VEC.
REQ-022 VEC, beat: vec_we=1, vec_addr=vec_idx, vec_wdata=data_in, combinational in the same cycle; vec_idx increments; after beat cols-1 go to VAL.
REQ-023 VAL, beat: latch data_in into val[slot]; go to COL; ipv_in and in_last are ignored.
REQ-024 COL, beat: latch data_in[6:0] into col[slot] and ipv_in into ipv[slot]; if ipv_in=1, row_count increments.
REQ-025 COL, beat with slot=K-1 or in_last=1: on the next cycle batch_valid=1 with the registered slots, then slot := 0; otherwise slot increments.
REQ-026 A partial batch SHALL zero-fill unused slots: val=0, col=0, ipv=0.
REQ-027 COL, beat with in_last=0: go to VAL; with in_last=1: go to WAIT.
REQ-028 Batch buses SHALL hold their value between pulses; batch_valid SHALL never be high on two consecutive cycles.
REQ-029 res_cnt SHALL increment on res_valid in any state except IDLE; res_valid in IDLE is ignored.
REQ-030 WAIT with res_cnt==row_count (the comparison includes the same-cycle res_valid increment): done=1 for one cycle, go to IDLE.
REQ-031 row_count and res_cnt wrap modulo 256; jobs with more than 255 rows are unsupported.
REQ-032 Empty rows (rows with no nonzero) are unsupported; the final nonzero SHALL carry ipv_in=1.
REQ-033 in_valid while in_ready=0 is ignored, and no beat transfers.

Reset
REQ-034 rst_n low SHALL immediately force: state IDLE; all counters, slots and batch buses 0; in_ready=1; vec_we, batch_valid, busy and done 0.
REQ-035 Reset asserted mid-job SHALL discard the partial batch and all pending results; no batch_valid or done pulse follows.

Verification
REQ-036 Shape 0x03, vector 1,2,3,4 -> four vec_we pulses at addr 0..3 with data 1..4; state VAL after the fourth beat.
REQ-037 Four pairs (5,c0),(6,c1),(7,c2,ipv),(8,c3,ipv,last) -> one batch_valid, batch_val=0x05060708, batch_ipv=4'b0011, row_count=2.
REQ-038 Six pairs, last on the sixth -> two batch_valid pulses; the second has slots 2 and 3 zeroed.
REQ-039 Two res_valid pulses in WAIT with row_count=2 -> done pulses exactly once, busy falls, in_ready=1.
REQ-040 res_valid coinciding with the final COL beat is counted; the WAIT exit is not missed.
REQ-041 rst_n pulsed during VAL after two pairs -> outputs at reset values, no batch_valid; a new shape beat is then accepted.
